cosine_job_sequencer: RTL and testbench



---
 rtl/cosine_job_sequencer.sv | 135 +++++++++++++
 tb/tb_cosine_job_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosine_job_sequencer.sv
// Cosine job sequencer: FIFO-buffered angle jobs -> one at a time to the core -> result on valid/ready; start 2 cycles after push.
// Input stalls when the FIFO is full, output holds until accepted; COS_SATURATE_EN clamps results to [-1.0,+1.0] Q8.8.
module cosine_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_x,
    input  logic [7:0]                 in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_ans,
    output logic                       out_err,
    output logic                       core_start,
    output logic [15:0]                core_x,
    output logic [7:0]                 core_y,
    input  logic                       core_done,
    input  logic [15:0]                core_ans,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic [15:0]   wait_cnt;
    logic [15:0]   fifo_x [DEPTH];
    logic [7:0]    fifo_y [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready = (fifo_count < CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (state == IDLE) && (fifo_count != '0);
    assign busy     = (state != IDLE);

    function automatic logic [15:0] clamp(input logic [15:0] a);
`ifdef COS_SATURATE_EN
        if ($signed(a) > $signed(16'h0100))
            return 16'h0100;
        else if ($signed(a) < $signed(16'hFF00))
            return 16'hFF00;
        else
            return a;
`else
        return a;
`endif
    endfunction

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= in_x;
            fifo_y[wr_ptr] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            out_valid  <= 1'b0;
            out_ans    <= '0;
            out_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        core_x     <= fifo_x[rd_ptr];
                        core_y     <= fifo_y[rd_ptr];
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (core_done) begin
                        out_ans   <= clamp(core_ans);
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_ans   <= 16'hFFFF;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cosine_job_sequencer.sv
// Directed bench for cosine_job_sequencer with a fixed-latency core model (answer = core_x + 0x0100).
module tb_cosine_job_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [7:0]  in_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ans;
    logic        out_err;
    logic        core_start;
    logic [15:0] core_x;
    logic [7:0]  core_y;
    logic        core_done;
    logic [15:0] core_ans;
    logic        busy;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    int   core_lat  = 5;
    int   core_cnt  = 0;
    logic model_done = 1'b0;
    logic late_done  = 1'b0;

    logic [15:0] exp_q [$];
    logic        mon_en    = 1'b0;
    int          n_got     = 0;
    logic        saw_full  = 1'b0;
    logic        full_rdy  = 1'b0;

    cosine_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans), .out_err(out_err),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_ans(core_ans),
        .busy(busy), .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign core_done = model_done | late_done;
    assign core_ans  = core_x + 16'h0100;

    // Done is driven at the negedge core_lat cycles after the start was seen, so it is sampled core_lat edges after WAIT entry.
    always @(negedge clk) begin
        if (rst) begin
            core_cnt   = 0;
            model_done = 1'b0;
        end else if (core_start) begin
            core_cnt   = core_lat;
            model_done = 1'b0;
        end else if (core_cnt > 0) begin
            core_cnt   = core_cnt - 1;
            model_done = (core_cnt == 0);
        end else begin
            model_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_ans(input logic [15:0] raw);
`ifdef COS_SATURATE_EN
        if ($signed(raw) > $signed(16'h0100)) return 16'h0100;
        if ($signed(raw) < $signed(16'hFF00)) return 16'hFF00;
`endif
        return raw;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (fifo_count == 3'd4) begin
                saw_full = 1'b1;
                if (in_ready) full_rdy = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("q_underflow", 32'(n_got), 32'd6);
                else
                    check($sformatf("burst_ans%0d", n_got), 32'(out_ans), 32'(exp_q.pop_front()));
                check($sformatf("burst_err%0d", n_got), 32'(out_err), 32'd0);
                n_got++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] x, input logic [7:0] y);
        int guard = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("push_stuck", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_wait"}, 32'(out_valid), 32'd1);
    endtask

    // Single job on an idle system with exact cycle checks.
    task automatic run_one(input string tag, input logic [15:0] x, input logic [7:0] y,
                           input int lat, input logic [15:0] ea, input logic ee);
        int k;
        core_lat = lat;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_start_early"}, 32'(core_start), 32'd0);
        check({tag, "_cnt1"}, 32'(fifo_count), 32'd1);
        @(negedge clk);
        check({tag, "_start"}, 32'(core_start), 32'd1);
        check({tag, "_core_x"}, 32'(core_x), 32'(x));
        check({tag, "_core_y"}, 32'(core_y), 32'(y));
        check({tag, "_cnt0"}, 32'(fifo_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        k = ((lat > TIMEOUT) ? TIMEOUT : lat) + 1;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(core_start), 32'd0);
        repeat (k - 2) @(negedge clk);
        check({tag, "_vld_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_ans"}, 32'(out_ans), 32'(ea));
        check({tag, "_err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic start_seen;
        logic vld_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        late_done = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ans", 32'(out_ans), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_x", 32'(core_x), 32'd0);
        check("rst_core_y", 32'(core_y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_done_busy", 32'(busy), 32'd0);
        check("stale_done_vld", 32'(out_valid), 32'd0);
        late_done = 1'b0;

        run_one("single", 16'h0000, 8'h01, 5, exp_ans(16'h0100), 1'b0);
        run_one("timeout", 16'h0040, 8'h02, 9, 16'hFFFF, 1'b1);
        run_one("after_to", 16'h0011, 8'h03, 4, exp_ans(16'h0111), 1'b0);
        run_one("done_wins", 16'h0022, 8'h04, 8, exp_ans(16'h0122), 1'b0);

        // Result held under backpressure with a second job queued behind it.
        core_lat = 5;
        push(16'h0020, 8'h05);
        push(16'h0030, 8'h06);
        wait_valid("hold_a");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_vld%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("hold_ans%0d", i), 32'(out_ans), 32'(exp_ans(16'h0120)));
            check($sformatf("hold_nostart%0d", i), 32'(core_start), 32'd0);
            @(negedge clk);
        end
        check("hold_queued", 32'(fifo_count), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_gap", 32'(core_start), 32'd0);
        @(negedge clk);
        check("b2b_start", 32'(core_start), 32'd1);
        check("b2b_core_x", 32'(core_x), 32'h0030);
        wait_valid("hold_b");
        check("hold_b_ans", 32'(out_ans), 32'(exp_ans(16'h0130)));
        out_ready = 1'b1;
        @(negedge clk);

        // Six back-to-back jobs, consumer always ready.
        core_lat = 6;
        mon_en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp_ans(16'h0100 + 16'(i * 16'h0010)));
            push(16'(i * 16'h0010), 8'(i));
        end
        for (int c = 0; c < 500 && n_got < 6; c++) @(negedge clk);
        check("burst_count", 32'(n_got), 32'd6);
        check("burst_full_seen", 32'(saw_full), 32'd1);
        check("burst_full_rdy", 32'(full_rdy), 32'd0);
        mon_en    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while a hung job waits with three more queued.
        core_lat = 1000;
        for (int i = 0; i < 4; i++) push(16'h0050 + 16'(i), 8'h07);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_done = 1'b1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        check("mid_rst_x", 32'(core_x), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        start_seen = 1'b0;
        vld_seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) late_done = 1'b0;
            if (core_start) start_seen = 1'b1;
            if (out_valid) vld_seen = 1'b1;
            @(negedge clk);
        end
        check("post_rst_no_start", 32'(start_seen), 32'd0);
        check("post_rst_no_vld", 32'(vld_seen), 32'd0);

        run_one("sat_hi", 16'h0003, 8'h08, 3, exp_ans(16'h0103), 1'b0);
        run_one("sat_lo", 16'hFDF0, 8'h09, 3, exp_ans(16'hFEF0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
